// File: rtl/mem_line_responder.sv
// Purpose : memory-side responder for the L1D line-transfer protocol; accepts one
//           LOAD/STORE line request, acknowledges the address, then moves 4 words.
// Latency : ACK_ADDR one cycle after acceptance, first data beat LATENCY cycles later.
// Backpr. : READY is low for the whole transfer; every beat waits on ACK_DATA_L1.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_valid/i_load/i_store      request strobe and operation (load wins if both)
//   i_addr                      byte address, bits [3:0] ignored
//   o_ready, o_ack_addr         idle indication, one-cycle address acknowledge
//   i_data_in, o_data_out       store beat in, registered load beat out
//   i_ack_data_l1               one-hot beat strobe from the cache
//   o_ack_data_mem              one-hot beat strobe from memory
//   o_err                       out-of-range request (only with MEM_RESP_BOUNDS_CHECK_EN)
//
// Optional feature macro: MEM_RESP_BOUNDS_CHECK_EN. When undefined, addresses wrap
// modulo the array size and there is no o_err port.
module mem_line_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   input  logic        i_load,
   input  logic        i_store,
   input  logic [31:0] i_addr,
   output logic        o_ready,
   output logic        o_ack_addr,
   input  logic [31:0] i_data_in,
   output logic [31:0] o_data_out,
   input  logic [3:0]  i_ack_data_l1,
   output logic [3:0]  o_ack_data_mem
`ifdef MEM_RESP_BOUNDS_CHECK_EN
   ,
   output logic        o_err
`endif
);

   localparam int LINES  = DEPTH_WORDS / 4;
   localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int AW     = $clog2(DEPTH_WORDS);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ADDR_ACK = 3'd1;
   localparam logic [2:0] S_WAIT     = 3'd2;
   localparam logic [2:0] S_RD       = 3'd3;
   localparam logic [2:0] S_WR       = 3'd4;

   logic [2:0]        r_state;
   logic [LINE_W-1:0] r_base;
   logic [1:0]        r_beat;
   logic [3:0]        r_cnt;
   logic              r_is_load;
   logic              r_err;
   logic              r_wr_ack;     // store beat sampled, acknowledge cycle in progress
   logic [31:0]       r_data_out;
   logic [31:0]       r_mem [DEPTH_WORDS];

   logic              w_oob;
   logic              w_accept;
   logic              w_rd_load;
   logic              w_wr_en;
   logic [1:0]        w_nxt_beat;
   logic [LINE_W+1:0] w_wr_full;
   logic [LINE_W+1:0] w_rd_full;
   logic [AW-1:0]     w_wr_word;
   logic [AW-1:0]     w_rd_word;
   logic [2:0]        w_beat_state;
   logic              w_unused;

`ifdef MEM_RESP_BOUNDS_CHECK_EN
   assign w_oob = (i_addr[31:4] >= 28'(LINES));
`else
   assign w_oob = 1'b0;
`endif

   // Low address bits (and, without the bounds check, the upper bits) are don't-care.
   assign w_unused = ^i_addr;

   assign w_accept     = i_valid && (i_load || i_store);
   assign w_beat_state = r_is_load ? S_RD : S_WR;

   // Truncating {line, beat} to AW bits gives the modulo-array wrap for free.
   assign w_wr_full = {r_base, r_beat};
   assign w_wr_word = w_wr_full[AW-1:0];
   assign w_nxt_beat = (r_state == S_RD) ? (r_beat + 2'd1) : 2'd0;
   assign w_rd_full = {r_base, w_nxt_beat};
   assign w_rd_word = w_rd_full[AW-1:0];

   assign w_wr_en = (r_state == S_WR) && !r_wr_ack && i_ack_data_l1[r_beat] && !r_err;

   // DATA_OUT is fetched on the edge that enters a read beat so it is already
   // registered and stable for the whole cycle its strobe is high.
   always_comb begin
      w_rd_load = 1'b0;
      case (r_state)
         S_ADDR_ACK: w_rd_load = r_is_load && (LATENCY == 0);
         S_WAIT:     w_rd_load = r_is_load && (r_cnt <= 4'd1);
         S_RD:       w_rd_load = i_ack_data_l1[r_beat] && (r_beat != 2'd3);
         default:    w_rd_load = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_beat     <= 2'd0;
         r_cnt      <= 4'd0;
         r_is_load  <= 1'b0;
         r_err      <= 1'b0;
         r_wr_ack   <= 1'b0;
         r_data_out <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_base    <= i_addr[4 +: LINE_W];
                  r_is_load <= i_load;
                  r_err     <= w_oob;
                  r_beat    <= 2'd0;
                  r_wr_ack  <= 1'b0;
                  r_state   <= S_ADDR_ACK;
               end
            end
            S_ADDR_ACK: begin
               r_cnt <= 4'(LATENCY);
               if (LATENCY == 0) r_state <= w_beat_state;
               else              r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt <= 4'd1) r_state <= w_beat_state;
               else               r_cnt   <= r_cnt - 4'd1;
            end
            S_RD: begin
               if (i_ack_data_l1[r_beat]) begin
                  if (r_beat == 2'd3) r_state <= S_IDLE;
                  else                r_beat  <= r_beat + 2'd1;
               end
            end
            S_WR: begin
               if (r_wr_ack) begin
                  r_wr_ack <= 1'b0;
                  if (r_beat == 2'd3) r_state <= S_IDLE;
                  else                r_beat  <= r_beat + 2'd1;
               end else if (i_ack_data_l1[r_beat]) begin
                  r_wr_ack <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_rd_load) r_data_out <= r_err ? 32'h0 : r_mem[w_rd_word];
      end
   end

   // Array contents survive reset; a beat only writes on a sampled strobe edge.
   always_ff @(posedge i_clk) begin
      if (w_wr_en) r_mem[w_wr_word] <= i_data_in;
   end

   assign o_ready        = (r_state == S_IDLE);
   assign o_ack_addr     = (r_state == S_ADDR_ACK);
   assign o_data_out     = r_data_out;
   assign o_ack_data_mem = ((r_state == S_RD) || ((r_state == S_WR) && r_wr_ack))
                           ? (4'b0001 << r_beat) : 4'b0000;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
   assign o_err          = r_err && (r_state != S_IDLE);
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Purpose : self-checking bench for mem_line_responder; a transaction-level model
//           derives the expected per-cycle outputs, one process compares every cycle.
// Latency : n/a (bench).  Backpressure: the bench plays the cache, including stalls.
module tb_mem_line_responder;
   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0, ld = 1'b0, st = 1'b0;
   logic [31:0] addr = 32'h0, din = 32'h0;
   logic [3:0]  ackl1 = 4'h0;
   logic        ready, ack_addr;
   logic [31:0] dout;
   logic [3:0]  ackm;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
   logic        err;
`endif

   mem_line_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_load(ld), .i_store(st),
      .i_addr(addr), .o_ready(ready), .o_ack_addr(ack_addr), .i_data_in(din),
      .o_data_out(dout), .i_ack_data_l1(ackl1), .o_ack_data_mem(ackm)
`ifdef MEM_RESP_BOUNDS_CHECK_EN
      , .o_err(err)
`endif
   );

   always #5 clk = ~clk;

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   int checks = 0, errors = 0;

   // Expected outputs for the current cycle, written by the stimulus/model.
   logic        exp_ready = 1'b1, exp_ack_addr = 1'b0, exp_err = 1'b0;
   logic [3:0]  exp_ackm = 4'h0;
   logic [31:0] exp_data = 32'h0;
   bit          exp_data_known = 1'b1;
   bit          chk_en = 1'b0;

   // Word-level memory model.
   logic [31:0] model_mem [DEPTH];
   bit          known [DEPTH];

   int          t_acc, t_beat0, t_rdy;
   logic [31:0] got [4];
   logic [31:0] wdata [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", {31'h0, ready}, {31'h0, exp_ready});
         chk("ack_addr", {31'h0, ack_addr}, {31'h0, exp_ack_addr});
         chk("ack_data_mem", {28'h0, ackm}, {28'h0, exp_ackm});
         if (exp_data_known) chk("data_out", dout, exp_data);
`ifdef MEM_RESP_BOUNDS_CHECK_EN
         chk("err", {31'h0, err}, {31'h0, exp_err});
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      exp_ready = 1'b1; exp_ack_addr = 1'b0; exp_ackm = 4'h0; exp_err = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, {31'h0, ready}, 32'h1);
      chk({tag, "_ack_addr"}, {31'h0, ack_addr}, 32'h0);
      chk({tag, "_ack_data_mem"}, {28'h0, ackm}, 32'h0);
      chk({tag, "_data_out"}, dout, 32'h0);
   endtask

   // One line transfer as seen by the cache. Timing follows the protocol rules:
   // address ack one cycle after acceptance, LAT wait cycles, then the beats.
   task automatic xfer(input logic l, input logic s, input logic [31:0] a,
                       input int stall_beat, input int stall_n,
                       input logic [3:0] stray, input int abort_beat);
      bit is_ld;
      bit oob;
      int base;
      int w;
      logic [3:0] bitm;
      is_ld = l;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
      oob = (a[31:4] >= 28'(DEPTH / 4));
`else
      oob = 1'b0;
`endif
      base = (int'(a[31:4]) % (DEPTH / 4)) * 4;

      valid = 1'b1; ld = l; st = s; addr = a; set_idle();
      t_acc = cyc_n;
      step();
      valid = 1'b0; ld = 1'b0; st = 1'b0; addr = $urandom;
      exp_ready = 1'b0; exp_ack_addr = 1'b1; exp_err = oob;
      step();
      exp_ack_addr = 1'b0;
      repeat (LAT) step();
      for (int i = 0; i < 4; i++) begin
         bitm = 4'b0001 << i;
         w = (i == stall_beat) ? stall_n : 0;
         if (is_ld) begin
            for (int j = 0; j <= w; j++) begin
               exp_ackm = bitm;
               exp_data = oob ? 32'h0 : model_mem[base + i];
               exp_data_known = oob || known[base + i];
               if (i == 0 && j == 0) t_beat0 = cyc_n;
               ackl1 = (j == w) ? bitm : (stray & ~bitm);
               if (j == w) got[i] = dout;
               step();
            end
         end else begin
            if (i == abort_beat) begin
               ackl1 = 4'h0; exp_ackm = 4'h0; din = wdata[i];
               #1 rst_n = 1'b0;
               #1 chk_reset_outputs("abort");
               set_idle(); exp_data = 32'h0; exp_data_known = 1'b1;
               step();
               rst_n = 1'b1; ackl1 = 4'h0;
               t_rdy = cyc_n;
               return;
            end
            for (int j = 0; j < w; j++) begin
               ackl1 = stray & ~bitm; din = $urandom; exp_ackm = 4'h0;
               step();
            end
            ackl1 = bitm; din = wdata[i]; exp_ackm = 4'h0;
            if (!oob) begin
               model_mem[base + i] = wdata[i];
               known[base + i] = 1'b1;
            end
            step();
            ackl1 = 4'h0; exp_ackm = bitm;
            step();
         end
      end
      ackl1 = 4'h0; set_idle();
      t_rdy = cyc_n;
   endtask

   task automatic chk_got(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
      chk({tag, "_w0"}, got[0], e0);
      chk({tag, "_w1"}, got[1], e1);
      chk({tag, "_w2"}, got[2], e2);
      chk({tag, "_w3"}, got[3], e3);
   endtask

   initial begin
      for (int k = 0; k < DEPTH; k++) known[k] = 1'b0;
      set_idle();
      repeat (2) @(posedge clk);
      #1 chk_reset_outputs("reset");
      rst_n = 1'b1;
      chk_en = 1'b1;
      step();

      // Preload line 0x40, then reset: array contents must survive reset.
      wdata = '{32'h11, 32'h12, 32'h13, 32'h14};
      xfer(1'b0, 1'b1, 32'h40, -1, 0, 4'h0, -1);
      rst_n = 1'b0; set_idle(); exp_data = 32'h0;
      #1 chk_reset_outputs("reset2");
      step();
      rst_n = 1'b1;
      step();

      // Basic load with immediate echo.
      xfer(1'b1, 1'b0, 32'h40, -1, 0, 4'h0, -1);
      chk("t1_first_beat_delay", t_beat0 - t_acc, 32'd4);
      chk("t1_ready_delay", t_rdy - t_acc, 32'd8);
      chk_got("t1", 32'h11, 32'h12, 32'h13, 32'h14);

      // Store (low address bits ignored), then back-to-back load.
      wdata = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      xfer(1'b0, 1'b1, 32'h8C, -1, 0, 4'h0, -1);
      chk("t2_store_ready_delay", t_rdy - t_acc, 32'd12);
      xfer(1'b1, 1'b0, 32'h80, -1, 0, 4'h0, -1);
      chk_got("t2", 32'hA0, 32'hA1, 32'hA2, 32'hA3);

      // Load stall on beat 1 for 5 cycles with a stray beat-2 strobe.
      xfer(1'b1, 1'b0, 32'h80, 1, 5, 4'b0100, -1);
      chk("t3_stall_ready_delay", t_rdy - t_acc, 32'd13);
      chk_got("t3", 32'hA0, 32'hA1, 32'hA2, 32'hA3);

      // Store with a stall and multi-hot strays on beat 2.
      wdata = '{32'h50, 32'h51, 32'h52, 32'h53};
      xfer(1'b0, 1'b1, 32'h40, 2, 3, 4'b1111, -1);

      // LOAD and STORE both high is a load.
      xfer(1'b1, 1'b1, 32'h40, -1, 0, 4'h0, -1);
      chk_got("t4_both", 32'h50, 32'h51, 32'h52, 32'h53);

      // VALID without an operation is not accepted.
      valid = 1'b1; ld = 1'b0; st = 1'b0; addr = 32'h40; set_idle();
      repeat (3) step();
      valid = 1'b0;
      repeat (2) step();

      // Reset during store beat 2: words 0-1 updated, 2-3 unchanged.
      wdata = '{32'h61, 32'h62, 32'h63, 32'h64};
      xfer(1'b0, 1'b1, 32'hC0, -1, 0, 4'h0, -1);
      wdata = '{32'h71, 32'h72, 32'h73, 32'h74};
      xfer(1'b0, 1'b1, 32'hC0, -1, 0, 4'h0, 2);
      step();
      xfer(1'b1, 1'b0, 32'hC0, -1, 0, 4'h0, -1);
      chk_got("t5_abort", 32'h71, 32'h72, 32'h63, 32'h64);

      // Line 0x1000: out of range with the bounds check, otherwise wraps to line 0.
      wdata = '{32'h81, 32'h82, 32'h83, 32'h84};
      xfer(1'b0, 1'b1, 32'h0, -1, 0, 4'h0, -1);
      wdata = '{32'h91, 32'h92, 32'h93, 32'h94};
      xfer(1'b0, 1'b1, 32'h1000, -1, 0, 4'h0, -1);
      xfer(1'b1, 1'b0, 32'h1000, -1, 0, 4'h0, -1);
`ifdef MEM_RESP_BOUNDS_CHECK_EN
      chk_got("t6_oob", 32'h0, 32'h0, 32'h0, 32'h0);
`else
      chk_got("t6_wrap", 32'h91, 32'h92, 32'h93, 32'h94);
`endif
      xfer(1'b1, 1'b0, 32'h0, -1, 0, 4'h0, -1);
`ifdef MEM_RESP_BOUNDS_CHECK_EN
      chk_got("t6_line0", 32'h81, 32'h82, 32'h83, 32'h84);
`else
      chk_got("t6_line0", 32'h91, 32'h92, 32'h93, 32'h94);
`endif

      repeat (3) step();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
